// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port ids, memory ops
// and the round-robin grant choice.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // On a tie the port that did not win last time is chosen.
    function automatic port_id_e pick_grant(
        input logic     req0,
        input logic     req1,
        input port_id_e last
    );
        port_id_e g;
        if (req0 && req1) begin
            if (last == PORT_I) begin
                g = PORT_D;
            end else begin
                g = PORT_I;
            end
        end else if (req1) begin
            g = PORT_D;
        end else begin
            g = PORT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/arb_req_reg.sv
// Latched request bundle (address, write data, byte enables, op); loads on a
// grant and holds steady for the whole physical transaction.
import mem_arbiter_pkg::*;

module arb_req_reg #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic [DATA_WIDTH/8-1:0] be_in,
    input  mem_op_e                 op_in,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic [DATA_WIDTH-1:0]   wdata_out,
    output logic [DATA_WIDTH/8-1:0] be_out,
    output mem_op_e                 op_out
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q,    be_d;
    mem_op_e               op_q,    op_d;

    // Next-state select: take the new bundle on load, otherwise hold.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_d    = op_q;
        if (load) begin
            addr_d  = addr_in;
            wdata_d = wdata_in;
            be_d    = be_in;
            op_d    = op_in;
        end else begin
            addr_d  = addr_q;
            wdata_d = wdata_q;
            be_d    = be_q;
            op_d    = op_q;
        end
    end

    // Request bundle registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            op_q    <= OP_READ;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_q    <= op_d;
        end
    end

    assign addr_out  = addr_q;
    assign wdata_out = wdata_q;
    assign be_out    = be_q;
    assign op_out    = op_q;

endmodule

// File: rtl/mem_arbiter_chk.sv
// Protocol checker: the two response pulses and the two physical strobes are
// each mutually exclusive.
module mem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic mem_resp_0,
    input logic mem_resp_1,
    input logic pmem_read,
    input logic pmem_write
);

    a_resp_onehot: assert property (@(posedge clk) disable iff (rst)
        !(mem_resp_0 && mem_resp_1));

    a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
        !(pmem_read && pmem_write));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises instruction-fetch (port 0) and data
// (port 1) requests onto one physical memory port with alternating tie-break.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read_0,
    input  logic [ADDR_WIDTH-1:0]   mem_address_0,
    output logic                    mem_resp_0,
    output logic [DATA_WIDTH-1:0]   mem_rdata_0,
    input  logic                    mem_read_1,
    input  logic                    mem_write_1,
    input  logic [ADDR_WIDTH-1:0]   mem_address_1,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_1,
    input  logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic                    mem_resp_1,
    output logic [DATA_WIDTH-1:0]   mem_rdata_1,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_WIDTH-1:0]   pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
    input  logic                    pmem_resp,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_e            state_q,      state_d;
    port_id_e              last_grant_q, last_grant_d;
    port_id_e              grant_q,      grant_d;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
    logic                  resp_0_q,     resp_0_d;
    logic                  resp_1_q,     resp_1_d;
    logic                  pmem_read_q,  pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;

    logic                  req0_s;
    logic                  req1_s;
    port_id_e              grant_sel_s;
    logic                  load_s;
    logic [ADDR_WIDTH-1:0] ld_addr_s;
    logic [DATA_WIDTH-1:0] ld_wdata_s;
    logic [BE_WIDTH-1:0]   ld_be_s;
    mem_op_e               ld_op_s;
    mem_op_e               op_s;

    assign req0_s      = mem_read_0;
    assign req1_s      = mem_read_1 | mem_write_1;
    assign grant_sel_s = pick_grant(req0_s, req1_s, last_grant_q);

    // Request bundle presented to the latch for whichever port is being granted.
    always_comb begin
        ld_addr_s  = mem_address_0;
        ld_wdata_s = '0;
        ld_be_s    = {BE_WIDTH{1'b1}};
        ld_op_s    = OP_READ;
        if (grant_sel_s == PORT_D) begin
            ld_addr_s  = mem_address_1;
            ld_wdata_s = mem_wdata_1;
            ld_be_s    = mem_byte_enable;
            if (mem_write_1) begin
                ld_op_s = OP_WRITE;
            end else begin
                ld_op_s = OP_READ;
            end
        end else begin
            ld_addr_s  = mem_address_0;
            ld_wdata_s = '0;
            ld_be_s    = {BE_WIDTH{1'b1}};
            ld_op_s    = OP_READ;
        end
    end

    arb_req_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_req_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .addr_in   (ld_addr_s),
        .wdata_in  (ld_wdata_s),
        .be_in     (ld_be_s),
        .op_in     (ld_op_s),
        .addr_out  (pmem_address),
        .wdata_out (pmem_wdata),
        .be_out    (pmem_byte_enable),
        .op_out    (op_s)
    );

    // FSM next-state: grant in IDLE, wait for memory in BUSY, pulse in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rdata_d      = rdata_q;
        resp_0_d     = 1'b0;
        resp_1_d     = 1'b0;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        load_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_s || req1_s) begin
                    load_s       = 1'b1;
                    grant_d      = grant_sel_s;
                    last_grant_d = grant_sel_s;
                    state_d      = ST_BUSY;
                    if (ld_op_s == OP_WRITE) begin
                        pmem_write_d = 1'b1;
                        pmem_read_d  = 1'b0;
                    end else begin
                        pmem_write_d = 1'b0;
                        pmem_read_d  = 1'b1;
                    end
                end else begin
                    state_d      = ST_IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (pmem_resp) begin
                    rdata_d      = pmem_rdata;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = ST_RESP;
                    if (grant_q == PORT_D) begin
                        resp_1_d = 1'b1;
                    end else begin
                        resp_0_d = 1'b1;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: begin
                // Dead cycle so a requester still holding its request is not re-served.
                state_d      = ST_IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_I;
            grant_q      <= PORT_I;
            rdata_q      <= '0;
            resp_0_q     <= 1'b0;
            resp_1_q     <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rdata_q      <= rdata_d;
            resp_0_q     <= resp_0_d;
            resp_1_q     <= resp_1_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    assign mem_resp_0  = resp_0_q;
    assign mem_resp_1  = resp_1_q;
    assign mem_rdata_0 = rdata_q;
    assign mem_rdata_1 = rdata_q;
    assign pmem_read   = pmem_read_q;
    assign pmem_write  = pmem_write_q;

    mem_arbiter_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .mem_resp_0 (resp_0_q),
        .mem_resp_1 (resp_1_q),
        .pmem_read  (pmem_read_q),
        .pmem_write (pmem_write_q)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs
// sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_read_0;
    logic [15:0] mem_address_0;
    logic        mem_resp_0;
    logic [15:0] mem_rdata_0;
    logic        mem_read_1;
    logic        mem_write_1;
    logic [15:0] mem_address_1;
    logic [15:0] mem_wdata_1;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp_1;
    logic [15:0] mem_rdata_1;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_0       (mem_read_0),
        .mem_address_0    (mem_address_0),
        .mem_resp_0       (mem_resp_0),
        .mem_rdata_0      (mem_rdata_0),
        .mem_read_1       (mem_read_1),
        .mem_write_1      (mem_write_1),
        .mem_address_1    (mem_address_1),
        .mem_wdata_1      (mem_wdata_1),
        .mem_byte_enable  (mem_byte_enable),
        .mem_resp_1       (mem_resp_1),
        .mem_rdata_1      (mem_rdata_1),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        step;
        total_cnt++;
        if ({mem_resp_0, mem_resp_1, pmem_read, pmem_write} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {mem_resp_0, mem_resp_1, pmem_read, pmem_write});
        else pass_cnt++;
        total_cnt++;
        if ({pmem_address, pmem_wdata, pmem_byte_enable} !== 34'h0)
            $display("FAIL reset_bundle: got %h/%h/%b want 0", pmem_address, pmem_wdata, pmem_byte_enable);
        else pass_cnt++;
        total_cnt++;
        if ({mem_rdata_0, mem_rdata_1} !== 32'h0)
            $display("FAIL reset_rdata: got %h/%h want 0", mem_rdata_0, mem_rdata_1);
        else pass_cnt++;
        rst = 1'b0;
        step;
    endtask

    task automatic test_port0_read;
        int rd_cnt = 0, wr_cnt = 0, r0 = 0, r1 = 0;
        logic [15:0] got = 16'h0;
        mem_read_0    = 1'b1;
        mem_address_0 = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            step;
            if (i == 0) begin
                total_cnt++;
                if (pmem_address !== 16'h0040)
                    $display("FAIL p0_addr: got %h want 0040", pmem_address);
                else pass_cnt++;
                total_cnt++;
                if (pmem_byte_enable !== 2'b11)
                    $display("FAIL p0_be: got %b want 11", pmem_byte_enable);
                else pass_cnt++;
            end
            rd_cnt += int'(pmem_read);
            wr_cnt += int'(pmem_write);
            r1     += int'(mem_resp_1);
            if (mem_resp_0) begin
                r0++;
                got        = mem_rdata_0;
                mem_read_0 = 1'b0;
            end
            pmem_resp  = (i == 2);
            pmem_rdata = (i == 2) ? 16'h1234 : 16'h0000;
        end
        total_cnt++;
        if (rd_cnt !== 3) $display("FAIL p0_read_cycles: got %0d want 3", rd_cnt); else pass_cnt++;
        total_cnt++;
        if (wr_cnt !== 0) $display("FAIL p0_write_cycles: got %0d want 0", wr_cnt); else pass_cnt++;
        total_cnt++;
        if (r0 !== 1 || r1 !== 0) $display("FAIL p0_resp_count: got %0d/%0d want 1/0", r0, r1); else pass_cnt++;
        total_cnt++;
        if (got !== 16'h1234) $display("FAIL p0_rdata: got %h want 1234", got); else pass_cnt++;
        total_cnt++;
        if (mem_rdata_0 !== 16'h1234) $display("FAIL p0_rdata_hold: got %h want 1234", mem_rdata_0); else pass_cnt++;
    endtask

    task automatic test_port1_write;
        int rd_cnt = 0, wr_cnt = 0, r0 = 0, r1 = 0;
        mem_write_1     = 1'b1;
        mem_address_1   = 16'h0101;
        mem_wdata_1     = 16'hABAB;
        mem_byte_enable = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step;
            if (i == 0) begin
                total_cnt++;
                if ({pmem_address, pmem_wdata, pmem_byte_enable} !== {16'h0101, 16'hABAB, 2'b10})
                    $display("FAIL p1w_bundle: got %h/%h/%b want 0101/abab/10", pmem_address, pmem_wdata, pmem_byte_enable);
                else pass_cnt++;
            end
            rd_cnt += int'(pmem_read);
            wr_cnt += int'(pmem_write);
            r0     += int'(mem_resp_0);
            if (mem_resp_1) begin
                r1++;
                mem_write_1 = 1'b0;
            end
            pmem_resp = (i == 0);
        end
        total_cnt++;
        if (wr_cnt !== 1 || rd_cnt !== 0) $display("FAIL p1w_strobes: got wr=%0d rd=%0d want 1/0", wr_cnt, rd_cnt); else pass_cnt++;
        total_cnt++;
        if (r1 !== 1 || r0 !== 0) $display("FAIL p1w_resp_count: got %0d/%0d want 1/0", r1, r0); else pass_cnt++;
    endtask

    task automatic test_addr_stable;
        int bad = 0, rd_cnt = 0, r1 = 0;
        mem_read_1      = 1'b1;
        mem_address_1   = 16'h0300;
        mem_byte_enable = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step;
            if (pmem_read && pmem_address !== 16'h0300) bad++;
            rd_cnt += int'(pmem_read);
            r1     += int'(mem_resp_1);
            mem_address_1 = 16'h0BAD + 16'(i);
            if (i == 1) mem_read_1 = 1'b0;
            pmem_resp  = (i == 2);
            pmem_rdata = 16'h5A5A;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL stable_addr: got %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++;
        if (rd_cnt !== 3) $display("FAIL stable_read_cycles: got %0d want 3", rd_cnt); else pass_cnt++;
        total_cnt++;
        if (r1 !== 1) $display("FAIL abandoned_resp: got %0d want 1", r1); else pass_cnt++;
        total_cnt++;
        if (mem_rdata_1 !== 16'h5A5A) $display("FAIL abandoned_rdata: got %h want 5a5a", mem_rdata_1); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int r0 = 0;
        mem_read_0    = 1'b1;
        mem_address_0 = 16'h0077;
        step;
        total_cnt++;
        if (pmem_read !== 1'b1) $display("FAIL rmid_pre_read: got %b want 1", pmem_read); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (pmem_read !== 1'b0 || pmem_address !== 16'h0000)
            $display("FAIL rmid_async: got read=%b addr=%h want 0/0000", pmem_read, pmem_address);
        else pass_cnt++;
        pmem_resp  = 1'b1;
        pmem_rdata = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            step;
            r0 += int'(mem_resp_0) + int'(mem_resp_1);
        end
        total_cnt++;
        if (r0 !== 0) $display("FAIL rmid_no_resp: got %0d want 0", r0); else pass_cnt++;
        pmem_resp = 1'b0;
        rst       = 1'b0;
        step;
        total_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0077)
            $display("FAIL rmid_regrant: got read=%b addr=%h want 1/0077", pmem_read, pmem_address);
        else pass_cnt++;
        pmem_resp  = 1'b1;
        pmem_rdata = 16'hBEEF;
        step;
        pmem_resp = 1'b0;
        total_cnt++;
        if (mem_resp_0 !== 1'b1 || mem_rdata_0 !== 16'hBEEF)
            $display("FAIL rmid_resp: got resp=%b rdata=%h want 1/beef", mem_resp_0, mem_rdata_0);
        else pass_cnt++;
        mem_read_0 = 1'b0;
        step;
        total_cnt++;
        if (mem_resp_0 !== 1'b0) $display("FAIL rmid_single_pulse: got %b want 0", mem_resp_0); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n = 0, overlap = 0, both = 0, extra = 0;
        int order [4];
        int exp_order [4];
        exp_order = '{1, 0, 1, 0};
        order     = '{-1, -1, -1, -1};
        rst = 1'b1;
        step;
        rst = 1'b0;
        mem_read_0      = 1'b1;
        mem_write_1     = 1'b1;
        mem_address_0   = 16'h0010;
        mem_address_1   = 16'h0020;
        mem_wdata_1     = 16'h1111;
        mem_byte_enable = 2'b11;
        for (int c = 0; c < 60 && n < 4; c++) begin
            step;
            if (mem_resp_0 && mem_resp_1) overlap++;
            if (pmem_read && pmem_write) both++;
            pmem_resp = pmem_read | pmem_write;
            if (mem_resp_0 || mem_resp_1) begin
                order[n] = mem_resp_1 ? 1 : 0;
                n++;
            end
            mem_read_0  = !mem_resp_0 && (n < 4);
            mem_write_1 = !mem_resp_1 && (n < 4);
        end
        mem_read_0  = 1'b0;
        mem_write_1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step;
            pmem_resp = pmem_read | pmem_write;
            extra += int'(mem_resp_0) + int'(mem_resp_1);
        end
        total_cnt++;
        if (n !== 4) $display("FAIL b2b_timeout: got %0d responses want 4", n); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (order[k] !== exp_order[k])
                $display("FAIL b2b_order%0d: got port %0d want port %0d", k, order[k], exp_order[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (overlap !== 0 || both !== 0) $display("FAIL b2b_overlap: got resp=%0d strobe=%0d want 0/0", overlap, both); else pass_cnt++;
        total_cnt++;
        if (extra !== 0) $display("FAIL b2b_double_service: got %0d extra want 0", extra); else pass_cnt++;
    endtask

    task automatic test_latency;
        int lat = 0, saw_wr = 0, saw_rd = 0;
        logic [15:0] wr_addr = 16'h0;
        mem_read_1      = 1'b1;
        mem_write_1     = 1'b1;
        mem_address_1   = 16'h0555;
        mem_wdata_1     = 16'h0F0F;
        mem_byte_enable = 2'b11;
        for (int c = 2; c < 10; c++) begin
            step;
            if (pmem_write) begin
                saw_wr++;
                wr_addr = pmem_address;
            end
            saw_rd += int'(pmem_read);
            pmem_resp = pmem_read | pmem_write;
            if (mem_resp_1 && lat == 0) begin
                lat         = c;
                mem_read_1  = 1'b0;
                mem_write_1 = 1'b0;
            end
        end
        total_cnt++;
        if (lat !== 3) $display("FAIL lat_cycles: got %0d want 3", lat); else pass_cnt++;
        total_cnt++;
        if (saw_wr !== 1 || saw_rd !== 0) $display("FAIL lat_rw_priority: got wr=%0d rd=%0d want 1/0", saw_wr, saw_rd); else pass_cnt++;
        total_cnt++;
        if (wr_addr !== 16'h0555) $display("FAIL lat_addr: got %h want 0555", wr_addr); else pass_cnt++;
    endtask

    initial begin
        rst             = 1'b1;
        mem_read_0      = 1'b0;
        mem_address_0   = 16'h0;
        mem_read_1      = 1'b0;
        mem_write_1     = 1'b0;
        mem_address_1   = 16'h0;
        mem_wdata_1     = 16'h0;
        mem_byte_enable = 2'b00;
        pmem_resp       = 1'b0;
        pmem_rdata      = 16'h0;
        test_reset;
        test_port0_read;
        test_port1_write;
        test_addr_stable;
        test_reset_mid;
        test_back_to_back;
        test_latency;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the pipeline's two request ports: port 0 is instruction fetch (read-only), port 1 is data (read/write with byte enables).
- Serialises both ports onto one physical memory port.
- Returns a single-cycle response pulse and read data to whichever port was granted.
- Sits between the datapath/caches and physical memory, and answers the same request/response protocol the datapath issues.

Parameters:
ADDR_WIDTH, 16, address width on all ports
DATA_WIDTH, 16, data width on all ports; byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_read_0  in  1  port 0 read request, held until mem_resp_0
mem_address_0  in  ADDR_WIDTH  port 0 address
mem_resp_0  out  1  port 0 completion pulse
mem_rdata_0  out  DATA_WIDTH  port 0 read data, valid when mem_resp_0=1
mem_read_1  in  1  port 1 read request
mem_write_1  in  1  port 1 write request
mem_address_1  in  ADDR_WIDTH  port 1 address
mem_wdata_1  in  DATA_WIDTH  port 1 write data
mem_byte_enable  in  DATA_WIDTH/8  port 1 write byte enables
mem_resp_1  out  1  port 1 completion pulse
mem_rdata_1  out  DATA_WIDTH  port 1 read data, valid when mem_resp_1=1
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_address  out  ADDR_WIDTH  physical address
pmem_wdata  out  DATA_WIDTH  physical write data
pmem_byte_enable  out  DATA_WIDTH/8  physical byte enables
pmem_resp  in  1  physical completion, single-cycle
pmem_rdata  in  DATA_WIDTH  physical read data, valid with pmem_resp

Behaviour:
- Reset values:
  - FSM state = IDLE; last_grant = port 0.
  - All outputs 0, including the address, wdata, byte-enable and rdata registers.
  - Reset is asynchronous: pmem strobes drop in the same cycle rst rises, even mid-transaction.
  - The in-flight request is discarded and no mem_resp is issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req0 = mem_read_0; req1 = mem_read_1 | mem_write_1.
  - If neither is set, stay in IDLE.
  - If only one is set, grant that port.
  - If both are set, grant the port not equal to last_grant (alternation), so port 1 wins the first tie after reset.
  - On grant, latch address, op, wdata and byte enables into the request registers, update last_grant, and go to BUSY.
  - Port 0 latches byte_enable = all ones and op = read.
  - If mem_read_1 and mem_write_1 are both set, latch a write.
- BUSY:
  - pmem_read or pmem_write is driven from the latched op.
  - pmem_address, pmem_wdata and pmem_byte_enable come from the latched registers and stay stable for the whole transaction.
  - Upstream inputs are ignored; changes on them do not affect the transaction.
  - When pmem_resp=1: capture pmem_rdata (writes also capture, value don't-care), deassert the pmem strobes on the next edge, and go to RESP.
- RESP:
  - mem_resp_<grant>=1 for exactly one cycle.
  - mem_rdata_<grant> = captured data; both rdata outputs are driven from one shared data register.
  - Then go to IDLE unconditionally.
  - This one-cycle gap lets the requester drop its request, so a held request is never serviced twice.
- Latency:
  - Request seen in IDLE at edge N; pmem strobe high in cycle N+1.
  - pmem_resp in cycle M gives mem_resp in cycle M+1.
  - Minimum request-to-resp latency is 3 cycles.
  - Throughput is at most one transaction per 3 cycles plus memory latency.
- Abandoned request: if the requester drops its request while BUSY, the transaction still completes and mem_resp still pulses.
- Never: mem_resp_0 and mem_resp_1 high in the same cycle; pmem_read and pmem_write high in the same cycle.
- The mem_rdata outputs hold their value between pulses.

Decomposition:
- Shared package: arbiter state enum (IDLE, BUSY, RESP) and a port-id typedef (PORT_I=0, PORT_D=1).
- Sub-module arb_req_reg: the latched request bundle (address, wdata, byte enable, op) with a load enable.
- FSM and grant logic stay in mem_arbiter.

Test Plan:
1. Port 0 only: mem_read_0=1, address 0x0040; pmem_resp returns 0x1234 two cycles after pmem_read -> pmem_address=0x0040, pmem_read=1 for 3 cycles, mem_resp_0 pulses once with mem_rdata_0=0x1234, mem_resp_1 stays 0.
2. Port 1 byte write: mem_write_1=1, address 0x0101, wdata 0xABAB, byte_enable 2'b10 -> pmem_write=1 with those exact values, pmem_read=0, single mem_resp_1.
3. Both request every cycle from reset -> grants D, I, D, I; responses alternate with no double service and no overlapping resp.
4. Port 1 changes its address mid-BUSY -> pmem_address keeps the originally latched value until pmem_resp.
5. rst asserted while BUSY, between clock edges -> pmem_read drops immediately, no mem_resp; after release a pending mem_read_0 is granted fresh.
6. mem_read_1 and mem_write_1 both high -> a write is issued; pmem_resp held for 1 cycle with memory at 0 latency -> request-to-resp latency is exactly 3 cycles.
